cla_addsub_pipe: RTL

//   Parametrised, pipelined carry-lookahead adder/subtractor.

---
 rtl/cla_addsub_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Result, carry, overflow and zero flags are computed in front of the first stage and shifted through LAT stages.
module cla_addsub_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4,
   parameter int unsigned LAT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned NG = WIDTH / GROUP;
   localparam int unsigned PW = WIDTH + 3;

   if ((WIDTH % GROUP) != 0 || LAT < 1 || LAT > 4) begin : g_bad_param
      $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and LAT must be 1..4");
   end

   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH:0]   c;
   logic [NG:0]      gc;
   logic [WIDTH-1:0] sum;
   logic [PW-1:0]    stage_in;
   logic             advance;

   assign bx    = in_sub ? ~in_b : in_b;
   assign p     = in_a ^ bx;
   assign g     = in_a & bx;
   assign gc[0] = in_cin ^ in_sub;

   // Group generate comes from a zero-carry-in chain; group carries then hop group to group.
   for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [GROUP:0] chain;
      logic           gg;
      logic           gp;

      assign chain[0] = 1'b0;
      for (genvar j = 0; j < GROUP; j++) begin : g_gen
         assign chain[j+1] = g[k*GROUP+j] | (p[k*GROUP+j] & chain[j]);
      end
      assign gg       = chain[GROUP];
      assign gp       = &p[k*GROUP +: GROUP];
      assign gc[k+1]  = gg | (gp & gc[k]);

      assign c[k*GROUP] = gc[k];
      for (genvar j = 1; j < GROUP; j++) begin : g_bit
         assign c[k*GROUP+j] = g[k*GROUP+j-1] | (p[k*GROUP+j-1] & c[k*GROUP+j-1]);
      end
   end
   assign c[WIDTH] = gc[NG];

   assign sum      = p ^ c[WIDTH-1:0];
   assign stage_in = {c[WIDTH], c[WIDTH] ^ c[WIDTH-1], ~|sum, sum};

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] vld_d;
   logic [PW-1:0]  pay_q [LAT];
   logic [PW-1:0]  pay_d [LAT];

   // All stages shift together on advance; bubbles keep their slot.
   always_comb begin
      vld_d = vld_q;
      pay_d = pay_q;
      if (advance) begin
         vld_d[0] = in_valid;
         pay_d[0] = stage_in;
         for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            pay_d[i] = pay_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            pay_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         pay_q <= pay_d;
      end
   end

   assign out_valid = vld_q[LAT-1];
   assign {out_cout, out_ovf, out_zero, out_sum} = pay_q[LAT-1];

endmodule
